cache_victim_buffer: RTL and testbench

- Single-entry writeback buffer directly downstream of the cache replacement logic.
- When the cache controller commits an eviction, the block consumes the one-hot VictimWay. If that way is dirty, it captures the way's tag, set and full line in one cycle. It then drains the line to the bus beat-by-beat, so the refill can proceed without waiting on the writeback.
- Also provides an address-match check so the controller cannot refill a line that is still pending in the buffer.

---
 rtl/cache_victim_buffer_pkg.sv | 23 ++
 rtl/cache_victim_buffer_if.sv | 54 +++++
 rtl/cache_victim_buffer_select.sv | 30 +++
 rtl/cache_victim_buffer.sv | 107 ++++++++++
 tb/tb_cache_victim_buffer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_victim_buffer_pkg.sv
// Shared constants and state encoding for the cache victim (writeback) buffer.
// Cache geometry lives here so the buffer, its interface and the flush logic agree.
package cache_victim_buffer_pkg;

  localparam int NUMWAYS    = 4;
  localparam int SETLEN     = 7;
  localparam int TAGLEN     = 21;
  localparam int LINELEN    = 512;
  localparam int BEATLEN    = 64;
  localparam int PA_BITS    = 34;

  localparam int BEATS      = LINELEN / BEATLEN;
  localparam int BEATCNTLEN = $clog2(BEATS);
  localparam int OFFSETLEN  = $clog2(LINELEN / 8);
  localparam int BEATBYTES  = BEATLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAITRESP
  } state_t;

endpackage

// File: rtl/cache_victim_buffer_if.sv
// Signal bundle between cache controller, victim buffer and write bus.
// CACHE_VICTIM_BUFFER_FORWARD_EN adds the FwdValid/FwdLine/FwdTake forwarding path.
interface cache_victim_buffer_if;
  import cache_victim_buffer_pkg::*;

  logic                        CaptureReq;
  logic [NUMWAYS-1:0]          VictimWay;
  logic [NUMWAYS-1:0]          DirtyWay;
  logic [NUMWAYS*TAGLEN-1:0]   TagWay;
  logic [SETLEN-1:0]           VictimSet;
  logic [LINELEN-1:0]          VictimLine;
  logic                        CaptureStall;
  logic [TAGLEN-1:0]           LookupTag;
  logic [SETLEN-1:0]           LookupSet;
  logic                        BufHit;
  logic                        BusReq;
  logic [PA_BITS-1:0]          BusAdr;
  logic [BEATLEN-1:0]          BusWData;
  logic                        BusLast;
  logic                        BusReady;
  logic                        BusDone;
  logic                        Busy;
`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
  logic                        FwdValid;
  logic [LINELEN-1:0]          FwdLine;
  logic                        FwdTake;
`endif

  // Handshakes: a beat transfers on a clock edge where BusReq && BusReady; while
  // BusReq is high and BusReady low, BusAdr/BusWData/BusLast stay stable. A
  // capture transfers on an edge where CaptureReq && !CaptureStall; the
  // controller holds CaptureReq and its victim data while CaptureStall is high.
  // The buffer is the master of the write bus, hence "master" is its side.
  modport master (
    input  CaptureReq, VictimWay, DirtyWay, TagWay, VictimSet, VictimLine,
    input  LookupTag, LookupSet, BusReady, BusDone,
`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
    input  FwdTake,
    output FwdValid, FwdLine,
`endif
    output CaptureStall, BufHit, BusReq, BusAdr, BusWData, BusLast, Busy
  );

  modport slave (
    output CaptureReq, VictimWay, DirtyWay, TagWay, VictimSet, VictimLine,
    output LookupTag, LookupSet, BusReady, BusDone,
`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
    output FwdTake,
    input  FwdValid, FwdLine,
`endif
    input  CaptureStall, BufHit, BusReq, BusAdr, BusWData, BusLast, Busy
  );

endinterface

// File: rtl/cache_victim_buffer_select.sv
// One-hot victim way to tag slice plus dirty reduction; purely combinational so
// the flush logic can reuse it. A multi-hot VictimWay is illegal.
module cache_victim_select #(
  parameter int NUMWAYS = cache_victim_buffer_pkg::NUMWAYS,
  parameter int TAGLEN  = cache_victim_buffer_pkg::TAGLEN
) (
  input  logic [NUMWAYS-1:0]        victim_way,
  input  logic [NUMWAYS-1:0]        dirty_way,
  input  logic [NUMWAYS*TAGLEN-1:0] tag_way,
  output logic                      dirty_hit,
  output logic [TAGLEN-1:0]         tag
);

  // And-or mux: an all-zero victim yields a zero tag and no dirty hit.
  always_comb begin
    tag = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (victim_way[i]) tag = tag | tag_way[i*TAGLEN +: TAGLEN];
    end
  end

  assign dirty_hit = |(victim_way & dirty_way);

`ifndef SYNTHESIS
  always_comb begin
    assert ($onehot0(victim_way));
  end
`endif

endmodule

// File: rtl/cache_victim_buffer.sv
// Single-entry writeback buffer: captures a dirty victim line in one cycle and
// drains it beat by beat. Optional forwarding: CACHE_VICTIM_BUFFER_FORWARD_EN.
module cache_victim_buffer
  import cache_victim_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  cache_victim_buffer_if.master  vb,
  output state_t                 dbg_state
);

  state_t                 state;
  logic                   valid;
  logic [BEATCNTLEN-1:0]  beat;
  logic [TAGLEN-1:0]      tag_q;
  logic [SETLEN-1:0]      set_q;
  logic [LINELEN-1:0]     line_q;

  logic                   dirty_hit;
  logic [TAGLEN-1:0]      sel_tag;
  logic                   drain;
  logic                   last_beat;
  logic                   buf_hit;
  logic                   fwd_cancel;
  logic [PA_BITS-1:0]     line_adr;

  cache_victim_select #(
    .NUMWAYS (NUMWAYS),
    .TAGLEN  (TAGLEN)
  ) u_select (
    .victim_way (vb.VictimWay),
    .dirty_way  (vb.DirtyWay),
    .tag_way    (vb.TagWay),
    .dirty_hit  (dirty_hit),
    .tag        (sel_tag)
  );

  assign drain     = (state == DRAIN);
  assign last_beat = (beat == BEATCNTLEN'(BEATS - 1));
  assign buf_hit   = valid && (vb.LookupTag == tag_q) && (vb.LookupSet == set_q);

`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
  // The controller reinstalls the forwarded line as dirty, so the writeback is moot.
  assign fwd_cancel  = vb.FwdTake && buf_hit && (state != IDLE);
  assign vb.FwdValid = buf_hit;
  assign vb.FwdLine  = line_q;
`else
  assign fwd_cancel  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      valid  <= 1'b0;
      beat   <= '0;
      tag_q  <= '0;
      set_q  <= '0;
      line_q <= '0;
    end else if (fwd_cancel) begin
      state <= IDLE;
      valid <= 1'b0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vb.CaptureReq && dirty_hit) begin
            tag_q  <= sel_tag;
            set_q  <= vb.VictimSet;
            line_q <= vb.VictimLine;
            valid  <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (vb.BusReady) begin
            if (last_beat) begin
              beat  <= '0;
              state <= WAITRESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WAITRESP: begin
          if (vb.BusDone) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign line_adr = {tag_q, set_q, {OFFSETLEN{1'b0}}};

  // Bus outputs are gated to zero outside DRAIN so an idle bus shows no stale data.
  assign vb.BusReq       = drain;
  assign vb.BusAdr       = drain ? (line_adr + PA_BITS'(beat) * PA_BITS'(BEATBYTES)) : '0;
  assign vb.BusWData     = drain ? line_q[{beat, {$clog2(BEATLEN){1'b0}}} +: BEATLEN] : '0;
  assign vb.BusLast      = drain && last_beat;
  assign vb.CaptureStall = valid;
  assign vb.Busy         = valid;
  assign vb.BufHit       = buf_hit;
  assign dbg_state       = state;

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Directed bench for cache_victim_buffer: vector table for capture decisions plus
// hand sequences for drain, backpressure, stall, lookup and reset corner cases.
module tb_cache_victim_buffer;
  import cache_victim_buffer_pkg::*;

  localparam int W = PA_BITS + BEATLEN + 1;

  typedef struct {
    logic [NUMWAYS-1:0] vw;
    logic [NUMWAYS-1:0] dw;
    logic [TAGLEN-1:0]  tag_base;
    logic [SETLEN-1:0]  set;
    logic [63:0]        seed;
    logic               exp_cap;
    int                 exp_way;
  } vec_t;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  cache_victim_buffer_if vb ();

  cache_victim_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .vb        (vb.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUMWAYS*TAGLEN-1:0] make_tagway(input logic [TAGLEN-1:0] base);
    logic [NUMWAYS*TAGLEN-1:0] tw;
    for (int w = 0; w < NUMWAYS; w++) tw[w*TAGLEN +: TAGLEN] = base + TAGLEN'(w);
    return tw;
  endfunction

  function automatic logic [LINELEN-1:0] make_line(input logic [63:0] seed);
    logic [LINELEN-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*BEATLEN +: BEATLEN] = seed * 64'(i + 1);
    return l;
  endfunction

  // scoreboard: expected {adr, data, last} per accepted beat
  task automatic push_line(input logic [TAGLEN-1:0] tag, input logic [SETLEN-1:0] set,
                           input logic [LINELEN-1:0] line);
    logic [PA_BITS-1:0] adr;
    for (int i = 0; i < BEATS; i++) begin
      adr = {tag, set, 6'b0} + PA_BITS'(i * 8);
      exp_q.push_back({adr, line[i*BEATLEN +: BEATLEN], (i == BEATS - 1)});
    end
  endtask

  // driver tasks
  task automatic drive_capture(input logic [NUMWAYS-1:0] vw, input logic [NUMWAYS-1:0] dw,
                               input logic [TAGLEN-1:0] tag_base, input logic [SETLEN-1:0] set,
                               input logic [LINELEN-1:0] line);
    vb.CaptureReq = 1'b1;
    vb.VictimWay  = vw;
    vb.DirtyWay   = dw;
    vb.TagWay     = make_tagway(tag_base);
    vb.VictimSet  = set;
    vb.VictimLine = line;
  endtask

  // ready pattern repeats every 4 cycles; checks every presented beat against the queue head
  task automatic drain(input logic [3:0] pat, input int beats, output int cycles);
    int taken = 0;
    int c = 0;
    logic [W-1:0] cur;
    while (taken < beats && c < 64) begin
      @(negedge clk);
      vb.BusReady = pat[c % 4];
      #1;
      cur = {vb.BusAdr, vb.BusWData, vb.BusLast};
      check("bus_req_drain", vb.BusReq, 1'b1);
      if (exp_q.size() == 0) begin
        check("beat_queue_empty", 1'b1, 1'b0);
      end else begin
        check("beat", cur, exp_q[0]);
        if (vb.BusReady) begin
          void'(exp_q.pop_front());
          taken++;
        end
      end
      c++;
    end
    if (taken < beats) check("drain_timeout", taken, beats);
    cycles = c;
  endtask

  task automatic finish_line();
    @(negedge clk);
    vb.BusReady = 1'b0;
    #1;
    check("waitresp_state", dbg_state, WAITRESP);
    check("waitresp_busreq", vb.BusReq, 1'b0);
    check("waitresp_busy", vb.Busy, 1'b1);
    vb.BusDone = 1'b1;
    @(negedge clk);
    vb.BusDone = 1'b0;
    #1;
    check("done_busy", vb.Busy, 1'b0);
    check("done_state", dbg_state, IDLE);
  endtask

  vec_t vecs[7];

  initial begin
    int cyc;
    logic [LINELEN-1:0] line;
    logic [LINELEN-1:0] line2;
    logic [TAGLEN-1:0]  etag;

    vecs[0] = '{4'b0001, 4'b0001, 21'h00100, 7'h01, 64'h0101_0101_0101_0101, 1'b1, 0};
    vecs[1] = '{4'b0010, 4'b0100, 21'h00200, 7'h02, 64'h0202_0202_0202_0202, 1'b0, 1};
    vecs[2] = '{4'b0100, 4'b0100, 21'h1ABCB, 7'h05, 64'h1111_1111_1111_1111, 1'b1, 2};
    vecs[3] = '{4'b1000, 4'b1111, 21'h15550, 7'h7F, 64'h0303_0303_0303_0303, 1'b1, 3};
    vecs[4] = '{4'b0000, 4'b1111, 21'h00400, 7'h04, 64'h0404_0404_0404_0404, 1'b0, 0};
    vecs[5] = '{4'b1000, 4'b0111, 21'h00500, 7'h05, 64'h0505_0505_0505_0505, 1'b0, 3};
    vecs[6] = '{4'b0010, 4'b0010, 21'h0F0F0, 7'h40, 64'hA5A5_0000_0000_0001, 1'b1, 1};

    reset         = 1'b0;
    vb.CaptureReq = 1'b0;
    vb.VictimWay  = '0;
    vb.DirtyWay   = '0;
    vb.TagWay     = '0;
    vb.VictimSet  = '0;
    vb.VictimLine = '0;
    vb.LookupTag  = '0;
    vb.LookupSet  = '0;
    vb.BusReady   = 1'b0;
    vb.BusDone    = 1'b0;
`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
    vb.FwdTake    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_stall", vb.CaptureStall, 1'b0);
    check("rst_bufhit", vb.BufHit, 1'b0);
    check("rst_busreq", vb.BusReq, 1'b0);
    check("rst_busadr", vb.BusAdr, '0);
    check("rst_buswdata", vb.BusWData, '0);
    check("rst_buslast", vb.BusLast, 1'b0);
    check("rst_busy", vb.Busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // table: capture decision, tag selection and full drain per vector
    for (int k = 0; k < 7; k++) begin
      line = make_line(vecs[k].seed);
      etag = vecs[k].tag_base + TAGLEN'(vecs[k].exp_way);
      @(negedge clk);
      drive_capture(vecs[k].vw, vecs[k].dw, vecs[k].tag_base, vecs[k].set, line);
      #1;
      check("idle_stall", vb.CaptureStall, 1'b0);
      @(negedge clk);
      vb.CaptureReq = 1'b0;
      vb.LookupTag  = etag;
      vb.LookupSet  = vecs[k].set;
      #1;
      check("vec_busy", vb.Busy, vecs[k].exp_cap);
      check("vec_stall", vb.CaptureStall, vecs[k].exp_cap);
      check("vec_busreq", vb.BusReq, vecs[k].exp_cap);
      check("vec_bufhit", vb.BufHit, vecs[k].exp_cap);
      if (vecs[k].exp_cap) begin
        vb.LookupTag = etag ^ 21'h1;
        #1;
        check("vec_bufhit_miss", vb.BufHit, 1'b0);
        vb.LookupTag = etag;
        push_line(etag, vecs[k].set, line);
        drain(4'b1111, BEATS, cyc);
        check("vec_drain_cycles", cyc, BEATS);
        finish_line();
      end
    end

    // spec drain: way 2 tag 0x1ABCD set 0x05, back-to-back beats, then stall around BusDone
    line = make_line(64'h1111_1111_1111_1111);
    @(negedge clk);
    drive_capture(4'b0100, 4'b0100, 21'h1ABCB, 7'h05, line);
    @(negedge clk);
    vb.CaptureReq = 1'b0;
    vb.LookupTag  = 21'h1ABCD;
    vb.LookupSet  = 7'h05;
    push_line(21'h1ABCD, 7'h05, line);
    check("first_adr", vb.BusAdr, {21'h1ABCD, 7'h05, 6'b0});
    drain(4'b1111, BEATS, cyc);
    check("spec_drain_cycles", cyc, 8);
    line2 = make_line(64'h0000_0000_C0DE_0001);
    @(negedge clk);
    vb.BusReady = 1'b0;
    drive_capture(4'b0010, 4'b0010, 21'h0F0EF, 7'h7F, line2);
    #1;
    check("wr_state", dbg_state, WAITRESP);
    check("wr_stall", vb.CaptureStall, 1'b1);
    check("wr_bufhit", vb.BufHit, 1'b1);
    check("wr_busy", vb.Busy, 1'b1);
    vb.LookupTag = 21'h1ABCC;
    #1;
    check("wr_bufhit_miss", vb.BufHit, 1'b0);
    vb.LookupTag = 21'h1ABCD;
    @(negedge clk);
    vb.BusDone = 1'b1;
    #1;
    check("done_cycle_stall", vb.CaptureStall, 1'b1);
    @(negedge clk);
    vb.BusDone = 1'b0;
    #1;
    check("post_done_stall", vb.CaptureStall, 1'b0);
    check("post_done_bufhit", vb.BufHit, 1'b0);
    check("post_done_busy", vb.Busy, 1'b0);
    @(negedge clk);
    vb.CaptureReq = 1'b0;
    vb.LookupTag  = 21'h0F0F0;
    vb.LookupSet  = 7'h7F;
    #1;
    check("late_capture_busy", vb.Busy, 1'b1);
    check("late_capture_bufhit", vb.BufHit, 1'b1);

    // backpressure 1,0,0,1 on the late-captured line
    push_line(21'h0F0F0, 7'h7F, line2);
    drain(4'b1001, BEATS, cyc);
    check("bp_queue_empty", exp_q.size(), 0);
    finish_line();

    // BusDone in IDLE is ignored
    @(negedge clk);
    vb.BusDone = 1'b1;
    @(negedge clk);
    vb.BusDone = 1'b0;
    #1;
    check("idle_done_busy", vb.Busy, 1'b0);

    // reset mid-drain after three accepted beats
    line = make_line(64'h0000_0000_DEAD_0001);
    @(negedge clk);
    drive_capture(4'b0001, 4'b0001, 21'h00123, 7'h11, line);
    @(negedge clk);
    vb.CaptureReq = 1'b0;
    push_line(21'h00123, 7'h11, line);
    drain(4'b1111, 3, cyc);
    @(negedge clk);
    vb.BusReady = 1'b0;
    #1;
    check("pre_rst_busreq", vb.BusReq, 1'b1);
    check("pre_rst_adr", vb.BusAdr, {21'h00123, 7'h11, 6'b0} + 34'd24);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_busreq", vb.BusReq, 1'b0);
    check("async_rst_busy", vb.Busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_state", dbg_state, IDLE);
    check("rel_busy", vb.Busy, 1'b0);

`ifdef CACHE_VICTIM_BUFFER_FORWARD_EN
    line = make_line(64'h0F0F_0000_0000_0003);
    @(negedge clk);
    drive_capture(4'b1000, 4'b1000, 21'h00050, 7'h22, line);
    @(negedge clk);
    vb.CaptureReq = 1'b0;
    vb.LookupTag  = 21'h00053;
    vb.LookupSet  = 7'h22;
    push_line(21'h00053, 7'h22, line);
    drain(4'b1111, 2, cyc);
    @(negedge clk);
    vb.BusReady = 1'b0;
    vb.FwdTake  = 1'b1;
    #1;
    check("fwd_valid", vb.FwdValid, 1'b1);
    check("fwd_line_lo", vb.FwdLine[127:0], line[127:0]);
    @(negedge clk);
    vb.FwdTake = 1'b0;
    #1;
    check("fwd_cancel_busy", vb.Busy, 1'b0);
    check("fwd_cancel_state", dbg_state, IDLE);
    exp_q.delete();
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
